// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter_ctrl command sequencer:
//   - command opcodes carried on cmd_op
//   - controller state encoding
//   - legal PRESCALE range
//   - burst_remaining(): converts a RUN operand into the number of pulses still
//     owed after the first one (operand 0 encodes a 16-pulse burst)
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam logic [1:0] OP_SET_MAX   = 2'b00;
    localparam logic [1:0] OP_SET_CARRY = 2'b01;
    localparam logic [1:0] OP_SET_DIR   = 2'b10;
    localparam logic [1:0] OP_RUN       = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CFG_MAX   = 2'd1,
        ST_CFG_CARRY = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int PRESCALE_MIN = 2;
    localparam int PRESCALE_MAX = 255;

    // The first pulse fires on the accept edge, so the burst still owes N-1.
    // Operand 0 means N = 16; 4'd0 - 1 wraps to 15, which is exactly that.
    function automatic logic [3:0] burst_remaining(input logic [3:0] n);
        return n - 4'd1;
    endfunction

endpackage

// File: rtl/inc_pulse_gen.sv
// -----------------------------------------------------------------------------
// inc_pulse_gen
// Produces a burst of single-cycle inc pulses, one every PRESCALE cycles.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load a new burst; the first pulse is driven from this edge
//   n          : burst length operand (0 means 16)
//   abort      : stop the running burst; no further pulses are issued
//   inc        : registered pulse output
//   last       : high while the final pulse of the burst is being driven
// -----------------------------------------------------------------------------
module inc_pulse_gen
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] n,
    input  logic       abort,
    output logic       inc,
    output logic       last
);

    // Out-of-range values are clamped so the counter width stays valid.
    localparam int PRESCALE_EFF = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN :
                                  (PRESCALE > PRESCALE_MAX) ? PRESCALE_MAX : PRESCALE;
    localparam logic [7:0] PRE_RELOAD = 8'(PRESCALE_EFF - 1);

    logic       active_q, active_d;
    logic       inc_q, inc_d;
    logic [3:0] rem_q, rem_d;   // pulses still owed after the current one
    logic [7:0] pre_q, pre_d;   // cycles until the next pulse slot

    assign last = active_q && inc_q && (rem_q == 4'd0);
    assign inc  = inc_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        active_d = active_q;
        inc_d    = 1'b0;
        rem_d    = rem_q;
        pre_d    = pre_q;

        if (start) begin
            active_d = 1'b1;
            inc_d    = 1'b1;
            rem_d    = burst_remaining(n);
            pre_d    = PRE_RELOAD;
        end else if (active_q) begin
            if (abort || last) begin
                active_d = 1'b0;
            end else if (pre_q == 8'd0) begin
                inc_d = 1'b1;
                rem_d = rem_q - 4'd1;
                pre_d = PRE_RELOAD;
            end else begin
                pre_d = pre_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            active_q <= 1'b0;
            inc_q    <= 1'b0;
            rem_q    <= 4'd0;
            pre_q    <= 8'd0;
        end else begin
            active_q <= active_d;
            inc_q    <= inc_d;
            rem_q    <= rem_d;
            pre_q    <= pre_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Command-driven sequencer for the 4-bit up/down counter. Decodes commands
// arriving over valid/ready into config pulses and timed inc bursts, and
// counts carry_out rising edges seen during a burst.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake (ready only in IDLE)
//   cmd_op[1:0], cmd_data[3:0]   : opcode and operand
//   abort                        : stop a running burst (honoured in RUN only)
//   done                         : one-cycle pulse when a burst ends
//   carry_cnt[3:0]               : saturating carry edge count of last burst
//   inc, up_down_sel, max_en,
//   carry_en, max_val[3:0]       : registered controls to the counter
//   carry_out                    : carry indication from the counter
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic       abort,
    output logic       done,
    output logic [3:0] carry_cnt,
    output logic       inc,
    output logic       up_down_sel,
    output logic       max_en,
    output logic       carry_en,
    output logic [3:0] max_val,
    input  logic       carry_out
);

    state_e     state_q, state_d;
    logic [3:0] max_val_q, max_val_d;
    logic       up_down_sel_q, up_down_sel_d;
    logic       max_en_q, max_en_d;
    logic       carry_en_q, carry_en_d;
    logic       done_q, done_d;
    logic [3:0] carry_cnt_q, carry_cnt_d;
    logic       carry_prev_q, carry_prev_d;

    logic cmd_accept;
    logic run_start;
    logic run_abort;
    logic pulse_last;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign run_start  = cmd_accept && (cmd_op == OP_RUN);
    assign run_abort  = abort && (state_q == ST_RUN);

    inc_pulse_gen #(
        .PRESCALE (PRESCALE)
    ) u_inc_pulse_gen (
        .clk   (clk),
        .reset (reset),
        .start (run_start),
        .n     (cmd_data),
        .abort (run_abort),
        .inc   (inc),
        .last  (pulse_last)
    );

    always_comb begin
        state_d       = state_q;
        max_val_d     = max_val_q;
        up_down_sel_d = up_down_sel_q;
        max_en_d      = 1'b0;
        carry_en_d    = 1'b0;
        done_d        = 1'b0;
        carry_cnt_d   = carry_cnt_q;
        carry_prev_d  = carry_out;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (cmd_op)
                        OP_SET_MAX: begin
                            max_val_d = cmd_data;
                            max_en_d  = 1'b1;
                            state_d   = ST_CFG_MAX;
                        end
                        OP_SET_CARRY: begin
                            max_val_d  = cmd_data;
                            carry_en_d = 1'b1;
                            state_d    = ST_CFG_CARRY;
                        end
                        OP_SET_DIR: begin
                            up_down_sel_d = cmd_data[0];
                        end
                        default: begin // OP_RUN
                            carry_cnt_d = 4'd0;
                            state_d     = ST_RUN;
                        end
                    endcase
                end
            end
            ST_CFG_MAX, ST_CFG_CARRY: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Rising edge of carry_out against its registered copy; the
                // final RUN cycle still counts because state_q is RUN there.
                if (carry_out && !carry_prev_q && (carry_cnt_q != 4'd15)) begin
                    carry_cnt_d = carry_cnt_q + 4'd1;
                end
                if (run_abort || pulse_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            max_val_q     <= 4'd0;
            up_down_sel_q <= 1'b0;
            max_en_q      <= 1'b0;
            carry_en_q    <= 1'b0;
            done_q        <= 1'b0;
            carry_cnt_q   <= 4'd0;
            carry_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_val_q     <= max_val_d;
            up_down_sel_q <= up_down_sel_d;
            max_en_q      <= max_en_d;
            carry_en_q    <= carry_en_d;
            done_q        <= done_d;
            carry_cnt_q   <= carry_cnt_d;
            carry_prev_q  <= carry_prev_d;
        end
    end

    assign max_val     = max_val_q;
    assign up_down_sel = up_down_sel_q;
    assign max_en      = max_en_q;
    assign carry_en    = carry_en_q;
    assign done        = done_q;
    assign carry_cnt   = carry_cnt_q;

endmodule
